// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: ALU op codes used by the decoder
// and the sequential multiply/divide unit, plus its state type.
package rv32i_pkg;

    localparam logic [3:0] ALU_MUL = 4'b1100;
    localparam logic [3:0] ALU_DIV = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Sequential 32-bit multiplier (low word) and signed restoring
// divider; one iteration per cycle, single-cycle done pulse.
module muldiv_seq
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      alu_ops,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = 5;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;

    logic            is_op, div_req, accept;
    logic            div0, ovf;
    logic [XLEN-1:0] mag1, mag2;
    logic [XLEN-1:0] mul_acc;
    logic [XLEN:0]   rshift;
    logic            fits;
    logic [XLEN-1:0] rsub, div_rem, div_quo, qfinal;

    // Decode the request and form one multiply and one divide step.
    always_comb begin
        is_op   = (alu_ops == ALU_MUL) || (alu_ops == ALU_DIV);
        div_req = (alu_ops == ALU_DIV);
        accept  = rst_n && (state_q == IDLE) && start && is_op && !flush;
        div0    = (rs2_val == '0);
        ovf     = (rs1_val == INT_MIN) && (rs2_val == '1);
        mag1    = rs1_val[XLEN-1] ? -rs1_val : rs1_val;
        mag2    = rs2_val[XLEN-1] ? -rs2_val : rs2_val;
        mul_acc = opb_q[0] ? acc_q + opa_q : acc_q;
        rshift  = {acc_q, opa_q[XLEN-1]};
        fits    = rshift >= {1'b0, opb_q};
        rsub    = rshift[XLEN-1:0] - opb_q;
        div_rem = fits ? rsub : rshift[XLEN-1:0];
        div_quo = {opa_q[XLEN-2:0], fits};
        qfinal  = neg_q ? -div_quo : div_quo;
    end

    // Next-state and datapath update for IDLE / RUN / DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rd_d     = rd_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rd_d     = rd_in;
                    is_div_d = div_req;
                    cnt_d    = '0;
                    neg_d    = 1'b0;
                    opa_d    = rs1_val;
                    opb_d    = rs2_val;
                    acc_d    = '0;
                    if (div_req && (div0 || ovf)) begin
                        acc_d   = div0 ? '1 : INT_MIN;
                        state_d = DONE;
                    end else if (div_req) begin
                        opa_d   = mag1;
                        opb_d   = mag2;
                        neg_d   = rs1_val[XLEN-1] ^ rs2_val[XLEN-1];
                        state_d = RUN;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_div_q) begin
                        acc_d = div_rem;
                        opa_d = div_quo;
                    end else begin
                        acc_d = mul_acc;
                        opa_d = opa_q << 1;
                        opb_d = opb_q >> 1;
                    end
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        acc_d   = is_div_q ? qfinal : mul_acc;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush) begin
                    result_d = acc_q;
                    rd_out_d = rd_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    // Outputs: the fresh result shows only during an unflushed done.
    always_comb begin
        busy   = (state_q != IDLE);
        stall  = accept || (state_q == RUN);
        done   = (state_q == DONE) && !flush;
        result = done ? acc_q : result_q;
        rd_out = done ? rd_q : rd_out_q;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: timeline reference model
// checked every cycle, plus directed literal cases.
module tb_muldiv_seq;
    import rv32i_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  alu_ops;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int nvec = 0;
    int nerr = 0;
    int ecnt = 0;

    // reference model state (timeline of the op in flight)
    bit          pend = 0;
    int          done_edge = 0;
    logic [31:0] exp_res = '0;
    logic [4:0]  exp_rd = '0;
    logic [31:0] held_res = '0;
    logic [4:0]  held_rd = '0;

    muldiv_seq #(.XLEN(32), .ITER(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .alu_ops (alu_ops),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .flush   (flush),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit valid_op(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == ALU_MUL) return a * b;
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
    endfunction

    function automatic bit is_special(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op == ALU_DIV) && ((b == 32'h0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Model advance at each edge, then compare all outputs mid-cycle.
    initial begin
        bit e_done, e_stall;
        forever begin
            @(posedge clk);
            ecnt++;
            if (!rst_n) begin
                pend = 0; held_res = '0; held_rd = '0;
            end else if (pend && ecnt == done_edge + 1) begin
                if (!flush) begin
                    held_res = exp_res; held_rd = exp_rd;
                end
                pend = 0;
            end else if (pend) begin
                if (flush) pend = 0;
            end else if (start && valid_op(alu_ops) && !flush) begin
                pend = 1;
                exp_res = ref_res(alu_ops, rs1_val, rs2_val);
                exp_rd = rd_in;
                done_edge = is_special(alu_ops, rs1_val, rs2_val) ? ecnt : ecnt + 32;
            end
            #6;
            if (!rst_n) begin
                pend = 0; held_res = '0; held_rd = '0;
            end
            e_done = pend && (ecnt == done_edge) && !flush;
            e_stall = (pend && ecnt < done_edge) ||
                      (!pend && rst_n && start && valid_op(alu_ops) && !flush);
            chk("busy", 32'(busy), 32'(pend));
            chk("stall", 32'(stall), 32'(e_stall));
            chk("done", 32'(done), 32'(e_done));
            chk("result", result, e_done ? exp_res : held_res);
            chk("rd_out", 32'(rd_out), 32'(e_done ? exp_rd : held_rd));
        end
    end

    // Issue one op from idle; report latency, stall cycles and result.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output int nst,
                         output logic [31:0] res, output logic [4:0] rdo);
        int acc_e;
        bit got;
        alu_ops = op; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
        acc_e = ecnt + 1;
        lat = -1; nst = 0; res = 'x; rdo = 'x; got = 0;
        #1;
        if (stall) nst++;
        @(posedge clk); #1;
        start = 1'b0; rs1_val = $urandom; rs2_val = $urandom; rd_in = 5'($urandom);
        for (int i = 0; i < 60 && !got; i++) begin
            #6;
            if (stall) nst++;
            if (done) begin
                got = 1; lat = ecnt + 1 - acc_e; res = result; rdo = rd_out;
            end
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($signed($urandom_range(40)) - 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, nst;
        logic [31:0] res;
        logic [4:0] rdo;
        rst_n = 1'b1; start = 1'b0; alu_ops = ALU_MUL; rs1_val = 32'd3;
        rs2_val = 32'd4; rd_in = 5'd1; flush = 1'b0;
        #1 rst_n = 1'b0;
        start = 1'b1;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", result, 0);
        chk("rst_rd", 32'(rd_out), 0);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(ALU_MUL, 32'd7, 32'd6, 5'd5, lat, nst, res, rdo);
        chk("mul7x6_res", res, 32'd42);
        chk("mul7x6_lat", 32'(lat), 33);
        chk("mul7x6_stall", 32'(nst), 33);
        chk("mul7x6_rd", 32'(rdo), 5);

        issue(ALU_DIV, -32'sd20, 32'd3, 5'd6, lat, nst, res, rdo);
        chk("div-20/3_res", res, 32'hFFFF_FFFA);
        chk("div-20/3_lat", 32'(lat), 33);
        issue(ALU_DIV, 32'd20, -32'sd3, 5'd7, lat, nst, res, rdo);
        chk("div20/-3_res", res, 32'hFFFF_FFFA);

        issue(ALU_DIV, 32'd5, 32'd0, 5'd8, lat, nst, res, rdo);
        chk("div0_res", res, 32'hFFFF_FFFF);
        chk("div0_lat", 32'(lat), 1);
        chk("div0_stall", 32'(nst), 1);
        issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, lat, nst, res, rdo);
        chk("ovf_res", res, 32'h8000_0000);
        chk("ovf_lat", 32'(lat), 1);

        issue(ALU_MUL, 32'hFFFF_FFFF, 32'd2, 5'd10, lat, nst, res, rdo);
        chk("mulneg_res", res, 32'hFFFF_FFFE);

        alu_ops = 4'b0000; start = 1'b1;
        #1 chk("badop_stall", 32'(stall), 0);
        @(posedge clk); #2;
        chk("badop_busy", 32'(busy), 0);
        start = 1'b0;
        @(posedge clk); #1;

        alu_ops = ALU_MUL; rs1_val = 32'd9; rs2_val = 32'd9; rd_in = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 0);
        chk("flush_result", result, 32'hFFFF_FFFE);
        chk("flush_rd", 32'(rd_out), 10);
        issue(ALU_MUL, 32'd3, 32'd4, 5'd11, lat, nst, res, rdo);
        chk("after_flush_res", res, 32'd12);
        chk("after_flush_lat", 32'(lat), 33);

        alu_ops = ALU_DIV; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_stall", 32'(stall), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_result", result, 0);
        chk("midrst_rd", 32'(rd_out), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(ALU_DIV, 32'd100, 32'd7, 5'd12, lat, nst, res, rdo);
        chk("div100/7_res", res, 32'd14);
        chk("div100/7_lat", 32'(lat), 33);
        chk("div100/7_rd", 32'(rdo), 12);

        for (int c = 0; c < 4000; c++) begin
            start = ($urandom % 3) == 0;
            case ($urandom % 6)
                0: alu_ops = 4'($urandom);
                1, 2: alu_ops = ALU_MUL;
                default: alu_ops = ALU_DIV;
            endcase
            rs1_val = pick();
            rs2_val = pick();
            rd_in = 5'($urandom);
            flush = ($urandom % 25) == 0;
            @(posedge clk); #1;
        end
        start = 1'b0; flush = 1'b0;
        repeat (40) @(posedge clk);
        #8;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
